// File: rtl/hex_display_ctrl.sv
// Registered multi-digit seven-segment controller: load/capture stage, decode/blink output stage.
// Optional macro HEX_ERR_MSG_EN: overflow shows "Err" instead of dashes on every digit.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld,
  input  logic [DATA_W-1:0]       din,
  input  logic                    clr,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic [NUM_DIGITS*7-1:0] hex,
  output logic                    ovf
);

  localparam int NIB_W = 4 * NUM_DIGITS;
  localparam int EXT_W = (DATA_W > NIB_W) ? DATA_W : NIB_W;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_R    = 7'b0101111;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SHOW,
    ST_OVF
  } state_e;

  typedef enum logic {
    PH_ON,
    PH_OFF
  } phase_e;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Stage 1: capture
  state_e           state_q, state_d;
  logic [NIB_W-1:0] val_q, val_d;
  logic             lz_q, lz_d;

  // Blink timebase
  logic [31:0]      cnt_q, cnt_d;
  phase_e           phase_q, phase_d;

  // Stage 2: registered outputs
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
  logic                    ovf_q, ovf_d;

  logic [EXT_W-1:0] din_ext;
  logic             fits;

  assign din_ext = EXT_W'(din);
  assign fits    = ((din_ext >> NIB_W) == '0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    lz_d    = lz_q;
    if (clr) begin
      state_d = ST_BLANK;
    end else if (ld) begin
      state_d = fits ? ST_SHOW : ST_OVF;
      val_d   = din_ext[NIB_W-1:0];
      lz_d    = lz_blank;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = PH_ON;
    end else if (cnt_q == 32'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end else begin
      cnt_d   = cnt_q + 32'd1;
    end
  end

  // lead[i] is set when digit i and every digit above it are zero
  logic [NUM_DIGITS-1:0] nz;
  logic [NUM_DIGITS-1:0] lead;
  logic                  run;

  always_comb begin
    nz = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nz[i] = |val_q[4*i +: 4];
    end
  end

  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      run = run & ~nz[NUM_DIGITS-1-k];
      lead[NUM_DIGITS-1-k] = run;
    end
  end

  always_comb begin
    hex_d = '1;
    ovf_d = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      case (state_q)
        ST_SHOW: begin
          if (lz_q && lead[i] && (i != 0)) begin
            hex_d[7*i +: 7] = SEG_OFF;
          end else begin
            hex_d[7*i +: 7] = seg7(val_q[4*i +: 4]);
          end
        end
        ST_OVF: begin
`ifdef HEX_ERR_MSG_EN
          if (i < 2) begin
            hex_d[7*i +: 7] = SEG_R;
          end else if (i == 2) begin
            hex_d[7*i +: 7] = SEG_E;
          end else begin
            hex_d[7*i +: 7] = SEG_OFF;
          end
`else
          hex_d[7*i +: 7] = SEG_DASH;
`endif
        end
        default: hex_d[7*i +: 7] = SEG_OFF;
      endcase
    end
    ovf_d = (state_q == ST_OVF);
    // Blink masks segments only; the overflow flag stays visible.
    if (phase_q == PH_OFF) begin
      hex_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      val_q   <= '0;
      lz_q    <= 1'b0;
      cnt_q   <= '0;
      phase_q <= PH_ON;
      hex_q   <= '1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      lz_q    <= lz_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

  assign hex = hex_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl with a behavioural display model (4 digits, 20-bit data, blink 4).
module tb_hex_display_ctrl;

  localparam int ND   = 4;
  localparam int DW   = 20;
  localparam int BDIV = 4;

  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] CH_R = 7'b0101111;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ld, clr, lz_blank, blink_en;
  logic [DW-1:0]   din;
  logic [ND*7-1:0] hex;
  logic            ovf;

  hex_display_ctrl #(
    .NUM_DIGITS(ND),
    .DATA_W    (DW),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .din     (din),
    .clr     (clr),
    .lz_blank(lz_blank),
    .blink_en(blink_en),
    .hex     (hex),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Model: what is latched (0 blank, 1 show, 2 overflow) and how long blink_en has been high.
  int              m_st, m_val, nb;
  bit              m_lz;
  logic [ND*7-1:0] exp_hex;
  logic            exp_ovf;

  function automatic logic [ND*7-1:0] render(input int st, input int val, input bit lz, input bit on);
    logic [ND*7-1:0] r;
    int h;
    int nib;
    r = '1;
    h = 0;
    for (int i = 0; i < ND; i++) if (((val >> (4*i)) & 15) != 0) h = i;
    for (int i = 0; i < ND; i++) begin
      nib = (val >> (4*i)) & 15;
      if (st == 1) r[7*i +: 7] = (lz && i > h) ? OFF : SEG_TAB[nib];
      else if (st == 2) begin
`ifdef HEX_ERR_MSG_EN
        r[7*i +: 7] = (i < 2) ? CH_R : (i == 2) ? SEG_TAB[14] : OFF;
`else
        r[7*i +: 7] = DASH;
`endif
      end
    end
    if (!on) r = '1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_val = 0; m_lz = 0; nb = 0;
      exp_hex = '1; exp_ovf = 1'b0;
    end else begin
      exp_hex = render(m_st, m_val, m_lz, ((nb / BDIV) % 2) == 0);
      exp_ovf = (m_st == 2);
      if (clr) m_st = 0;
      else if (ld) begin
        m_st  = (int'(din) < (1 << (4*ND))) ? 1 : 2;
        m_val = int'(din) % (1 << (4*ND));
        m_lz  = lz_blank;
      end
      if (blink_en) nb++;
      else nb = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    check_eq("hex", 32'(hex), 32'(exp_hex));
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic load(input logic [DW-1:0] v, input logic lz);
    ld = 1'b1; din = v; lz_blank = lz;
    step();
    ld = 1'b0;
  endtask

  logic [ND*7-1:0] err_exp;
  int on_cnt;
  bit found;

  initial begin
    rst_n = 1'b0; ld = 0; clr = 0; lz_blank = 0; blink_en = 0; din = '0;
    #12;
    rst_n = 1'b1;
    check_eq("reset_hex", 32'(hex), 32'h0fffffff);
    check_eq("reset_ovf", 32'(ovf), 32'd0);
    step(); step();

    load(20'h0BEEF, 1'b0);
    step();
    check_eq("beef", 32'(hex), 32'({SEG_TAB[11], SEG_TAB[14], SEG_TAB[14], SEG_TAB[15]}));

    load(20'h00042, 1'b1);
    step();
    check_eq("lz_42", 32'(hex), 32'({OFF, OFF, SEG_TAB[4], SEG_TAB[2]}));
    load(20'h00000, 1'b1);
    step();
    check_eq("lz_zero", 32'(hex), 32'({OFF, OFF, OFF, SEG_TAB[0]}));

    load(20'h12345, 1'b0);
    step();
`ifdef HEX_ERR_MSG_EN
    err_exp = {OFF, SEG_TAB[14], CH_R, CH_R};
`else
    err_exp = {4{DASH}};
`endif
    check_eq("ovf_hex", 32'(hex), 32'(err_exp));
    check_eq("ovf_flag", 32'(ovf), 32'd1);

    ld = 1'b1; lz_blank = 1'b0;
    din = 20'h01111; step();
    din = 20'h02222; step();
    check_eq("b2b_1", 32'(hex), 32'({4{SEG_TAB[1]}}));
    din = 20'h03333; step();
    check_eq("b2b_2", 32'(hex), 32'({4{SEG_TAB[2]}}));
    ld = 1'b0; step();
    check_eq("b2b_3", 32'(hex), 32'({4{SEG_TAB[3]}}));

    clr = 1'b1; ld = 1'b1; din = 20'h05555; step();
    clr = 1'b0; ld = 1'b0; step();
    check_eq("clr_ld", 32'(hex), 32'h0fffffff);

    load(20'h000AB, 1'b0);
    step();
    blink_en = 1'b1;
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (hex != '1) on_cnt++;
    end
    check_eq("blink_on_cnt", 32'(on_cnt), 32'd8);
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (hex == '1) found = 1;
    end
    check_eq("blink_off_seen", 32'(found), 32'd1);
    step();
    blink_en = 1'b0;
    step(); step();
    check_eq("blink_drop", 32'(hex), 32'({SEG_TAB[0], SEG_TAB[0], SEG_TAB[10], SEG_TAB[11]}));

    load(20'h01234, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_hex", 32'(hex), 32'h0fffffff);
    check_eq("rst_mid_ovf", 32'(ovf), 32'd0);
    #2;
    rst_n = 1'b1;
    step(); step(); step();
    check_eq("rst_stay_blank", 32'(hex), 32'h0fffffff);

    for (int k = 0; k < 600; k++) begin
      ld  = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 19) == 0);
      lz_blank = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      case ($urandom_range(0, 3))
        0: din = DW'($urandom_range(0, 255));
        1: din = DW'($urandom);
        2: din = DW'($urandom_range(0, 65535));
        default: din = '0;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
